// File: rtl/rf_sb.sv
// Register file with two write ports, a pending-load scoreboard and
// optional write-through bypass on both combinational read ports.
module rf_sb #(
    parameter int RW        = 16,
    parameter int REGNO     = 8,
    parameter int REGNO_LOG = 3,
    parameter bit ZERO_R0   = 1'b0,
    parameter bit BYPASS    = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_wa_en,
    input  logic [REGNO_LOG-1:0] i_wa_sel,
    input  logic [RW-1:0]        i_wa_d,
    input  logic                 i_wb_en,
    input  logic [REGNO_LOG-1:0] i_wb_sel,
    input  logic [RW-1:0]        i_wb_d,
    input  logic                 i_iss_en,
    input  logic [REGNO_LOG-1:0] i_iss_sel,
    input  logic [REGNO_LOG-1:0] i_lout_sel,
    input  logic [REGNO_LOG-1:0] i_rout_sel,
    output logic [RW-1:0]        o_lout,
    output logic [RW-1:0]        o_rout,
    output logic                 o_lbusy,
    output logic                 o_rbusy,
    output logic [REGNO-1:0]     o_busy,
    output logic                 o_err
);

    logic [RW-1:0]        r_mem [REGNO];
    logic [REGNO-1:0]     r_busy;
    logic                 r_err;

    logic                 w_wa_ok;
    logic                 w_wb_ok;
    logic                 w_iss_ok;
    logic                 w_coll;
    logic                 w_wa_haz;
    logic                 w_fwd_a;
    logic                 w_fwd_b;
    logic [REGNO_LOG-1:0] w_rsel [2];
    logic [RW-1:0]        w_rdat [2];
    logic [1:0]           w_rbusy;

    // r0 traffic is dropped entirely when r0 is hardwired to zero
    assign w_wa_ok  = i_wa_en  && !(ZERO_R0 && i_wa_sel  == '0);
    assign w_wb_ok  = i_wb_en  && !(ZERO_R0 && i_wb_sel  == '0);
    assign w_iss_ok = i_iss_en && !(ZERO_R0 && i_iss_sel == '0);

    assign w_coll   = w_wa_ok && w_wb_ok && (i_wa_sel == i_wb_sel);
    assign w_wa_haz = w_wa_ok && r_busy[i_wa_sel];

    // Forwarding is masked in reset so every read returns zero
    assign w_fwd_a  = BYPASS && i_rst_n && w_wa_ok;
    assign w_fwd_b  = BYPASS && i_rst_n && w_wb_ok;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < REGNO; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wa_ok) r_mem[i_wa_sel] <= i_wa_d;
            if (w_wb_ok) r_mem[i_wb_sel] <= i_wb_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_wb_ok)  r_busy[i_wb_sel]  <= 1'b0;
            if (w_iss_ok) r_busy[i_iss_sel] <= 1'b1;
            if (w_coll || w_wa_haz) r_err <= 1'b1;
        end
    end

    assign w_rsel[0] = i_lout_sel;
    assign w_rsel[1] = i_rout_sel;

    // Read ports follow the write priority: port B over port A over stored
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rdat[p]  = r_mem[w_rsel[p]];
            w_rbusy[p] = r_busy[w_rsel[p]];
            if (w_fwd_b && i_wb_sel == w_rsel[p]) begin
                w_rdat[p]  = i_wb_d;
                w_rbusy[p] = 1'b0;
            end else if (w_fwd_a && i_wa_sel == w_rsel[p]) begin
                w_rdat[p]  = i_wa_d;
            end
            if (ZERO_R0 && w_rsel[p] == '0) w_rdat[p] = '0;
        end
    end

    assign o_lout  = w_rdat[0];
    assign o_rout  = w_rdat[1];
    assign o_lbusy = w_rbusy[0];
    assign o_rbusy = w_rbusy[1];
    assign o_busy  = r_busy;
    assign o_err   = r_err;

endmodule

// File: tb/tb_rf_sb.sv
// Bench for rf_sb: directed table, corner sequences and a random run
// against a reference model, on two parameter sets sharing one stimulus.
module tb_rf_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wa_en, wb_en, iss_en;
    logic [2:0]  wa_sel, wb_sel, iss_sel, lsel, rsel;
    logic [15:0] wa_d, wb_d;

    logic [15:0] lout [2];
    logic [15:0] rout [2];
    logic        lb [2];
    logic        rb [2];
    logic [7:0]  busy [2];
    logic        err [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_sb #(.ZERO_R0(1'b0), .BYPASS(1'b1)) u0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wa_en(wa_en), .i_wa_sel(wa_sel), .i_wa_d(wa_d),
        .i_wb_en(wb_en), .i_wb_sel(wb_sel), .i_wb_d(wb_d),
        .i_iss_en(iss_en), .i_iss_sel(iss_sel),
        .i_lout_sel(lsel), .i_rout_sel(rsel),
        .o_lout(lout[0]), .o_rout(rout[0]),
        .o_lbusy(lb[0]), .o_rbusy(rb[0]),
        .o_busy(busy[0]), .o_err(err[0])
    );

    rf_sb #(.ZERO_R0(1'b1), .BYPASS(1'b0)) u1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wa_en(wa_en), .i_wa_sel(wa_sel), .i_wa_d(wa_d),
        .i_wb_en(wb_en), .i_wb_sel(wb_sel), .i_wb_d(wb_d),
        .i_iss_en(iss_en), .i_iss_sel(iss_sel),
        .i_lout_sel(lsel), .i_rout_sel(rsel),
        .o_lout(lout[1]), .o_rout(rout[1]),
        .o_lbusy(lb[1]), .o_rbusy(rb[1]),
        .o_busy(busy[1]), .o_err(err[1])
    );

    typedef struct {
        logic        wa_en;
        logic [2:0]  wa_sel;
        logic [15:0] wa_d;
        logic        wb_en;
        logic [2:0]  wb_sel;
        logic [15:0] wb_d;
        logic        iss_en;
        logic [2:0]  iss_sel;
        logic [2:0]  lsel;
        logic [2:0]  rsel;
        logic [15:0] e_l;
        logic [15:0] e_r;
        logic        e_lb;
        logic        e_rb;
        logic [7:0]  e_busy;
        logic        e_err;
    } vec_t;

    vec_t tbl [10];

    // model state: instance 0 has ZERO_R0=0/BYPASS=1, instance 1 the reverse
    logic [15:0] mreg  [2][8];
    bit          mbusy [2][8];
    bit          merr  [2];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic a_en, input logic [2:0] a_s,
                         input logic [15:0] a_d, input logic b_en,
                         input logic [2:0] b_s, input logic [15:0] b_d,
                         input logic i_en, input logic [2:0] i_s,
                         input logic [2:0] l_s, input logic [2:0] r_s);
        wa_en = a_en; wa_sel = a_s; wa_d = a_d;
        wb_en = b_en; wb_sel = b_s; wb_d = b_d;
        iss_en = i_en; iss_sel = i_s;
        lsel = l_s; rsel = r_s;
    endtask

    task automatic idle(input logic [2:0] l_s, input logic [2:0] r_s);
        drive(0, 0, 0, 0, 0, 0, 0, 0, l_s, r_s);
    endtask

    function automatic vec_t mk(
        input logic a_en, input logic [2:0] a_s, input logic [15:0] a_d,
        input logic b_en, input logic [2:0] b_s, input logic [15:0] b_d,
        input logic i_en, input logic [2:0] i_s,
        input logic [2:0] l_s, input logic [2:0] r_s,
        input logic [15:0] el, input logic [15:0] er,
        input logic elb, input logic erb,
        input logic [7:0] ebusy, input logic eerr);
        vec_t v;
        v.wa_en = a_en; v.wa_sel = a_s; v.wa_d = a_d;
        v.wb_en = b_en; v.wb_sel = b_s; v.wb_d = b_d;
        v.iss_en = i_en; v.iss_sel = i_s;
        v.lsel = l_s; v.rsel = r_s;
        v.e_l = el; v.e_r = er; v.e_lb = elb; v.e_rb = erb;
        v.e_busy = ebusy; v.e_err = eerr;
        return v;
    endfunction

    function automatic void m_reset();
        for (int k = 0; k < 2; k++) begin
            merr[k] = 0;
            for (int s = 0; s < 8; s++) begin
                mreg[k][s]  = '0;
                mbusy[k][s] = 0;
            end
        end
    endfunction

    function automatic logic [15:0] m_rd(input int k, input logic [2:0] s);
        logic [15:0] v;
        if (k == 1 && s == 0) return '0;
        v = mreg[k][s];
        if (k == 0) begin
            if (wa_en && wa_sel == s) v = wa_d;
            if (wb_en && wb_sel == s) v = wb_d;
        end
        return v;
    endfunction

    function automatic logic m_bz(input int k, input logic [2:0] s);
        return mbusy[k][s] && !(k == 0 && wb_en && wb_sel == s);
    endfunction

    function automatic logic [7:0] m_vec(input int k);
        logic [7:0] v;
        for (int s = 0; s < 8; s++) v[s] = mbusy[k][s];
        return v;
    endfunction

    function automatic void m_step();
        bit a, b, i;
        for (int k = 0; k < 2; k++) begin
            a = wa_en  && !(k == 1 && wa_sel  == 0);
            b = wb_en  && !(k == 1 && wb_sel  == 0);
            i = iss_en && !(k == 1 && iss_sel == 0);
            if (a && b && wa_sel == wb_sel) merr[k] = 1;
            if (a && mbusy[k][wa_sel]) merr[k] = 1;
            if (a) mreg[k][wa_sel] = wa_d;
            if (b) mreg[k][wb_sel] = wb_d;
            if (b) mbusy[k][wb_sel] = 0;
            if (i) mbusy[k][iss_sel] = 1;
        end
    endfunction

    task automatic chk_model();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rnd%0d lout", k), lout[k], m_rd(k, lsel));
            chk($sformatf("rnd%0d rout", k), rout[k], m_rd(k, rsel));
            chk($sformatf("rnd%0d lbusy", k), lb[k], m_bz(k, lsel));
            chk($sformatf("rnd%0d rbusy", k), rb[k], m_bz(k, rsel));
            chk($sformatf("rnd%0d busy", k), busy[k], m_vec(k));
            chk($sformatf("rnd%0d err", k), err[k], merr[k]);
        end
    endtask

    initial begin
        tbl[0] = mk(1,3,16'hBEEF, 0,0,0, 0,0, 3,0, 16'hBEEF,0,     0,0, 8'h00,0);
        tbl[1] = mk(0,0,0,        0,0,0, 0,0, 3,3, 16'hBEEF,16'hBEEF,0,0, 8'h00,0);
        tbl[2] = mk(0,0,0,        0,0,0, 1,2, 2,3, 0,16'hBEEF,   0,0, 8'h00,0);
        tbl[3] = mk(0,0,0,        0,0,0, 0,0, 2,2, 0,0,          1,1, 8'h04,0);
        tbl[4] = mk(0,0,0, 1,2,16'h00A5, 0,0, 2,3, 16'h00A5,16'hBEEF,0,0, 8'h04,0);
        tbl[5] = mk(0,0,0,        0,0,0, 0,0, 2,2, 16'h00A5,16'h00A5,0,0, 8'h00,0);
        tbl[6] = mk(0,0,0, 1,4,16'h0044, 1,4, 4,2, 16'h0044,16'h00A5,0,0, 8'h00,0);
        tbl[7] = mk(0,0,0,        0,0,0, 0,0, 4,4, 16'h0044,16'h0044,1,1, 8'h10,0);
        tbl[8] = mk(1,4,16'h7777, 0,0,0, 0,0, 4,3, 16'h7777,16'hBEEF,1,0, 8'h10,0);
        tbl[9] = mk(0,0,0,        0,0,0, 0,0, 4,3, 16'h7777,16'hBEEF,1,0, 8'h10,1);

        rst_n = 1'b0;
        idle(0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst busy0", busy[0], 8'h00);
        chk("rst err0", err[0], 1'b0);
        chk("rst lout0", lout[0], 16'h0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(tbl[i].wa_en, tbl[i].wa_sel, tbl[i].wa_d,
                  tbl[i].wb_en, tbl[i].wb_sel, tbl[i].wb_d,
                  tbl[i].iss_en, tbl[i].iss_sel, tbl[i].lsel, tbl[i].rsel);
            #1;
            chk($sformatf("tbl%0d lout", i), lout[0], tbl[i].e_l);
            chk($sformatf("tbl%0d rout", i), rout[0], tbl[i].e_r);
            chk($sformatf("tbl%0d lbusy", i), lb[0], tbl[i].e_lb);
            chk($sformatf("tbl%0d rbusy", i), rb[0], tbl[i].e_rb);
            chk($sformatf("tbl%0d busy", i), busy[0], tbl[i].e_busy);
            chk($sformatf("tbl%0d err", i), err[0], tbl[i].e_err);
        end

        // fill busy with r0..r3, then reset mid-cycle with no edge
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 1, 3'(s), 0, 0);
        end
        @(negedge clk);
        idle(3, 3);
        #1;
        chk("pre-rst busy0", busy[0], 8'h1F);
        chk("pre-rst busy1", busy[1], 8'h1E);
        chk("pre-rst err0", err[0], 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst busy0", busy[0], 8'h00);
        chk("arst err0", err[0], 1'b0);
        chk("arst busy1", busy[1], 8'h00);
        chk("arst lout0", lout[0], 16'h0);
        for (int s = 0; s < 8; s++) begin
            lsel = 3'(s);
            rsel = 3'(7 - s);
            #1;
            chk($sformatf("arst l%0d", s), lout[0], 16'h0);
            chk($sformatf("arst r%0d", 7 - s), rout[0], 16'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // r0 handling and no-bypass behaviour on instance 1
        @(negedge clk);
        drive(1, 0, 16'hFFFF, 1, 0, 16'h1234, 1, 0, 0, 0);
        #1;
        chk("z0 same lout1", lout[1], 16'h0);
        @(negedge clk);
        drive(1, 3, 16'hBEEF, 0, 0, 0, 0, 0, 0, 3);
        #1;
        chk("z0 lout1", lout[1], 16'h0);
        chk("z0 busy1", busy[1], 8'h00);
        chk("z0 err1", err[1], 1'b0);
        chk("nobyp rout1", rout[1], 16'h0);
        chk("byp rout0", rout[0], 16'hBEEF);
        chk("r0 coll err0", err[0], 1'b1);
        @(negedge clk);
        idle(3, 0);
        #1;
        chk("nobyp next lout1", lout[1], 16'hBEEF);

        // collision: port B wins, sticky error
        @(negedge clk);
        drive(1, 5, 16'h1111, 1, 5, 16'h2222, 0, 0, 5, 5);
        #1;
        chk("coll byp lout0", lout[0], 16'h2222);
        chk("coll nobyp lout1", lout[1], 16'h0);
        chk("coll pre err1", err[1], 1'b0);
        @(negedge clk);
        idle(5, 5);
        #1;
        chk("coll lout1", lout[1], 16'h2222);
        chk("coll err1", err[1], 1'b1);
        repeat (3) @(negedge clk);
        #1;
        chk("coll sticky err1", err[1], 1'b1);

        // random run against the model
        @(negedge clk);
        rst_n = 1'b0;
        idle(0, 0);
        m_reset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if ($urandom_range(99) == 0) begin
                rst_n = 1'b0;
                idle(3'($urandom_range(7)), 3'($urandom_range(7)));
                m_reset();
                #1;
                chk_model();
            end else begin
                rst_n = 1'b1;
                drive($urandom_range(99) < 50, 3'($urandom_range(7)),
                      16'($urandom),
                      $urandom_range(99) < 40, 3'($urandom_range(7)),
                      16'($urandom),
                      $urandom_range(99) < 35, 3'($urandom_range(7)),
                      3'($urandom_range(7)), 3'($urandom_range(7)));
                #1;
                chk_model();
                m_step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
